// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: shared widths, register count and FSM state encoding
// for the register-file debug dumper.
package reg_dump_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam int NUM_REGS   = 32;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t SEND = 2'd1;
   localparam state_t DONE = 2'd2;

   // Next register index; relies on natural REG_ADDR_W-bit wrap (31 -> 0).
   function automatic logic [REG_ADDR_W-1:0] addr_inc(input logic [REG_ADDR_W-1:0] a);
      return a + REG_ADDR_W'(1);
   endfunction

endpackage

// File: rtl/reg_dump.sv
// reg_dump: walks an inclusive, wrap-around range of register addresses
// through a combinational read port and streams (addr, data) pairs out
// over a valid/ready handshake, one word per cycle at full rate.
// Optional feature macro: REG_DUMP_FREEZE_EN adds the freeze output,
// which the core uses to gate RegWrite so the dump is an atomic snapshot.
//
// Handshake: a word transfers on a rising clk edge where out_valid and
// out_ready are both high; while out_valid is high and out_ready low,
// out_addr/out_data/out_last hold stable and out_valid stays high.
module reg_dump
   import reg_dump_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [REG_ADDR_W-1:0] first_reg,
   input  logic [REG_ADDR_W-1:0] last_reg,
   output logic [REG_ADDR_W-1:0] rd_addr,
   input  logic [REG_DATA_W-1:0] rd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [REG_ADDR_W-1:0] out_addr,
   output logic [REG_DATA_W-1:0] out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done
`ifdef REG_DUMP_FREEZE_EN
   ,
   output logic                  freeze
`endif
);

   state_t                  state_q, state_d;
   logic                    out_valid_q, out_valid_d;
   logic [REG_ADDR_W-1:0]   out_addr_q, out_addr_d;
   logic [REG_DATA_W-1:0]   out_data_q, out_data_d;
   logic [REG_ADDR_W-1:0]   last_q, last_d;

   logic                    hs;
   logic                    at_last;

   // A word is accepted this cycle, and whether it ends the range.
   assign hs      = out_valid_q && out_ready;
   assign at_last = (state_q == SEND) && (out_addr_q == last_q);

   // State register and datapath flops; reset aborts any dump in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         last_q      <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
         last_q      <= last_d;
      end
   end

   // Next-state logic: IDLE -> SEND on start, SEND -> DONE on final handshake.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SEND;
         SEND:    if (hs && at_last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: capture the first word on start, advance on each non-final handshake.
   always_comb begin
      out_valid_d = out_valid_q;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;
      last_d      = last_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               last_d      = last_reg;
               out_data_d  = rd_data;
               out_addr_d  = first_reg;
               out_valid_d = 1'b1;
            end
         end
         SEND: begin
            if (hs) begin
               if (at_last) begin
                  out_valid_d = 1'b0;
               end else begin
                  out_data_d = rd_data;
                  out_addr_d = addr_inc(out_addr_q);
               end
            end
         end
         default: begin
            out_valid_d = 1'b0;
         end
      endcase
   end

   // Outputs: read address looks one word ahead so the next word is ready on handshake.
   always_comb begin
      rd_addr   = (state_q == IDLE) ? first_reg : addr_inc(out_addr_q);
      out_valid = out_valid_q;
      out_addr  = out_addr_q;
      out_data  = out_data_q;
      out_last  = at_last;
      busy      = (state_q != IDLE);
      done      = (state_q == DONE);
   end

`ifdef REG_DUMP_FREEZE_EN
   logic freeze_q, freeze_d;

   // Freeze covers every SEND cycle up to and including the final handshake.
   always_comb begin
      freeze_d = ((state_q == IDLE) && start) ||
                 ((state_q == SEND) && !(hs && at_last));
   end

   // Freeze register; dropped by reset so an aborted dump releases writes.
   always_ff @(posedge clk) begin
      if (rst) freeze_q <= 1'b0;
      else     freeze_q <= freeze_d;
   end

   assign freeze = freeze_q;
`endif

endmodule
